// File: rtl/bnn_pkg.sv
// Shared types and constants for the binary 3x3 convolution engine.
package bnn_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WLOAD,
        S_HDR,
        S_ROWS,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [15:0] END_MARK = 16'h00FF;

    localparam int W_KERN_LSB = 0;
    localparam int W_KERN_MSB = 8;
    localparam int W_T_LSB    = 9;
    localparam int W_T_MSB    = 12;

    // Legal image side is N_MIN..DATA_W; N_W holds any side up to 63.
    localparam int N_MIN = 3;
    localparam int N_W   = 6;

    function automatic logic [3:0] popcount9(input logic [8:0] v);
        logic [3:0] cnt;
        cnt = '0;
        for (int j = 0; j < 9; j++) begin
            cnt = cnt + {3'b000, v[j]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/bnn_window_eval.sv
// Combinational evaluation of one output row: XNOR-popcount of each 3x3 tap
// group against the kernel, thresholded; columns past N-3 are forced to 0.
module bnn_window_eval
    import bnn_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] row0,
    input  logic [DATA_W-1:0] row1,
    input  logic [DATA_W-1:0] row2,
    input  logic [8:0]        kernel,
    input  logic [3:0]        thresh,
    input  logic [N_W-1:0]    n,
    output logic [DATA_W-1:0] out_row
);

    logic [8:0] taps;

    always_comb begin
        out_row = '0;
        taps    = '0;
        for (int i = 0; i < DATA_W - 2; i++) begin
            // tap bit 3r+c: row r (0 = oldest), column offset c
            taps = {row2[i+2], row2[i+1], row2[i],
                    row1[i+2], row1[i+1], row1[i],
                    row0[i+2], row0[i+1], row0[i]};
            if (i + 3 <= int'(n)) begin
                out_row[i] = (popcount9(~(taps ^ kernel)) > thresh);
            end
        end
    end

endmodule

// File: rtl/bnn_conv3x3_mk.sv
// Binary 3x3 convolution engine: streams headed images from the input SRAM,
// applies NUM_K preloaded kernels per output row and writes thresholded rows.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for run
// S_WLOAD | loading NUM_K weight words (NUM_K+1 cycles)
// S_HDR   | consuming an image header (size, end mark or illegal)
// S_ROWS  | shifting one input row into the 3-row window
// S_WRITE | NUM_K output writes for the current window, reads stalled
// S_DONE  | one-cycle done pulse, then back to idle
module bnn_conv3x3_mk
    import bnn_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12,
    parameter int NUM_K  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] dut_sram_read_address,
    input  logic [DATA_W-1:0] sram_dut_read_data,
    output logic [ADDR_W-1:0] dut_wmem_read_address,
    input  logic [15:0]       wmem_dut_read_data,
    output logic [ADDR_W-1:0] dut_sram_write_address,
    output logic [DATA_W-1:0] dut_sram_write_data,
    output logic              wr_enable
);

    state_t            state;
    logic [DATA_W-1:0] win0, win1, win2;
    logic [8:0]        kern [0:7];
    logic [3:0]        thr  [0:7];
    logic [3:0]        wcnt;
    logic [3:0]        wcnt_m1;
    logic [2:0]        kcnt;
    logic [N_W-1:0]    n_reg;
    logic [N_W-1:0]    row_cnt;
    logic [N_W-1:0]    row_nxt;
    logic [31:0]       hdr32;
    logic              hdr_end;
    logic              hdr_bad;
    logic [DATA_W-1:0] eval_row;
    logic              unused_wbits;

    assign wcnt_m1      = wcnt - 4'd1;
    assign row_nxt      = row_cnt + N_W'(1);
    assign hdr32        = 32'(sram_dut_read_data);
    assign hdr_end      = (hdr32 == 32'(END_MARK));
    assign hdr_bad      = (hdr32 < 32'(N_MIN)) || (hdr32 > 32'(DATA_W));
    assign unused_wbits = ^wmem_dut_read_data[15:W_T_MSB+1];

    bnn_window_eval #(
        .DATA_W (DATA_W)
    ) u_eval (
        .row0    (win0),
        .row1    (win1),
        .row2    (win2),
        .kernel  (kern[kcnt]),
        .thresh  (thr[kcnt]),
        .n       (n_reg),
        .out_row (eval_row)
    );

    // Write strobe and data are decoded from the state register so that the
    // write port is active in exactly the WRITE cycles and nowhere else.
    assign wr_enable           = (state == S_WRITE);
    assign dut_sram_write_data = wr_enable ? eval_row : '0;

    // The read address runs one word ahead of the word on the data bus; it is
    // held when a row leads into WRITE so the next row is still pending after
    // the stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            state                  <= S_IDLE;
            busy                   <= 1'b0;
            done                   <= 1'b0;
            err                    <= 1'b0;
            dut_sram_read_address  <= '0;
            dut_wmem_read_address  <= '0;
            dut_sram_write_address <= '0;
            win0                   <= '0;
            win1                   <= '0;
            win2                   <= '0;
            wcnt                   <= '0;
            kcnt                   <= '0;
            n_reg                  <= '0;
            row_cnt                <= '0;
            for (int i = 0; i < 8; i++) begin
                kern[i] <= '0;
                thr[i]  <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (run) begin
                        state                  <= S_WLOAD;
                        busy                   <= 1'b1;
                        err                    <= 1'b0;
                        dut_sram_read_address  <= '0;
                        dut_wmem_read_address  <= '0;
                        dut_sram_write_address <= '0;
                        wcnt                   <= '0;
                        kcnt                   <= '0;
                    end
                end
                S_WLOAD: begin
                    if (wcnt != 4'd0) begin
                        kern[wcnt_m1[2:0]] <= wmem_dut_read_data[W_KERN_MSB:W_KERN_LSB];
                        thr[wcnt_m1[2:0]]  <= wmem_dut_read_data[W_T_MSB:W_T_LSB];
                    end
                    if (wcnt == 4'(NUM_K)) begin
                        state                 <= S_HDR;
                        dut_sram_read_address <= dut_sram_read_address + 1'b1;
                    end else begin
                        wcnt                  <= wcnt + 4'd1;
                        dut_wmem_read_address <= dut_wmem_read_address + 1'b1;
                    end
                end
                S_HDR: begin
                    if (hdr_end) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else if (hdr_bad) begin
                        state <= S_IDLE;
                        err   <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        state                 <= S_ROWS;
                        n_reg                 <= hdr32[N_W-1:0];
                        row_cnt               <= '0;
                        dut_sram_read_address <= dut_sram_read_address + 1'b1;
                    end
                end
                S_ROWS: begin
                    win0    <= win1;
                    win1    <= win2;
                    win2    <= sram_dut_read_data;
                    row_cnt <= row_nxt;
                    if (row_nxt >= N_W'(3)) begin
                        state <= S_WRITE;
                        kcnt  <= '0;
                    end else begin
                        dut_sram_read_address <= dut_sram_read_address + 1'b1;
                    end
                end
                S_WRITE: begin
                    dut_sram_write_address <= dut_sram_write_address + 1'b1;
                    if (kcnt == 3'(NUM_K - 1)) begin
                        kcnt                  <= '0;
                        dut_sram_read_address <= dut_sram_read_address + 1'b1;
                        state                 <= (row_cnt == n_reg) ? S_HDR : S_ROWS;
                    end else begin
                        kcnt <= kcnt + 3'd1;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bnn_conv3x3_mk.sv
// Bench for bnn_conv3x3_mk: three instances (NUM_K = 1, 2, 3) share behavioural
// SRAM models; expected writes are queued from a reference model as images are built.
module tb_bnn_conv3x3_mk;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 12;
    localparam int NI     = 3;

    typedef struct packed {
        logic [1:0]        inst;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic clk;
    logic reset;
    logic [NI-1:0] run_v;
    logic [NI-1:0] busy_v, done_v, err_v, wr_v;
    logic [ADDR_W-1:0] raddr_v [NI];
    logic [ADDR_W-1:0] waddr_v [NI];
    logic [ADDR_W-1:0] oaddr_v [NI];
    logic [DATA_W-1:0] rdata_v [NI];
    logic [DATA_W-1:0] odata_v [NI];
    logic [15:0]       wdata_v [NI];

    logic [DATA_W-1:0] imem [0:4095];
    logic [15:0]       wmem [0:7];

    wr_t obs [0:255];
    int  obs_cnt;
    wr_t exp_q [$];
    int  n_cmp, n_bad;
    int  ip, exp_addr;
    logic [8:0] kw [0:7];
    logic [3:0] kt [0:7];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        bnn_conv3x3_mk #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .NUM_K  (g + 1)
        ) u_dut (
            .clk                    (clk),
            .reset                  (reset),
            .run                    (run_v[g]),
            .busy                   (busy_v[g]),
            .done                   (done_v[g]),
            .err                    (err_v[g]),
            .dut_sram_read_address  (raddr_v[g]),
            .sram_dut_read_data     (rdata_v[g]),
            .dut_wmem_read_address  (waddr_v[g]),
            .wmem_dut_read_data     (wdata_v[g]),
            .dut_sram_write_address (oaddr_v[g]),
            .dut_sram_write_data    (odata_v[g]),
            .wr_enable              (wr_v[g])
        );
    end

    always @(posedge clk) begin
        for (int g = 0; g < NI; g++) begin
            rdata_v[g] <= imem[raddr_v[g]];
            wdata_v[g] <= wmem[waddr_v[g][2:0]];
        end
    end

    initial obs_cnt = 0;
    always @(negedge clk) begin
        for (int g = 0; g < NI; g++) begin
            if (wr_v[g] === 1'b1 && obs_cnt < 256) begin
                obs[obs_cnt] <= '{inst: 2'(g), addr: oaddr_v[g], data: odata_v[g]};
                obs_cnt      <= obs_cnt + 1;
            end
        end
    end

    function automatic logic [DATA_W-1:0] model_row(input logic [DATA_W-1:0] a,
            input logic [DATA_W-1:0] b, input logic [DATA_W-1:0] c,
            input logic [8:0] w, input int t, input int n);
        logic [DATA_W-1:0] res;
        logic [8:0] win;
        int pop;
        res = '0;
        for (int i = 0; i + 3 <= n; i++) begin
            win = {c[i+2], c[i+1], c[i], b[i+2], b[i+1], b[i], a[i+2], a[i+1], a[i]};
            pop = 9 - $countones(win ^ w);
            if (pop > t) res[i] = 1'b1;
        end
        return res;
    endfunction

    task automatic set_kernel(input int k, input logic [8:0] w, input logic [3:0] t);
        kw[k]   = w;
        kt[k]   = t;
        wmem[k] = {3'b000, t, w};
    endtask

    task automatic new_job();
        ip       = 0;
        exp_addr = 0;
        exp_q.delete();
    endtask

    task automatic add_image(input int g, input int n, input logic [DATA_W-1:0] rows[$]);
        wr_t e;
        imem[ip] = DATA_W'(n);
        for (int r = 0; r < n; r++) imem[ip + 1 + r] = rows[r];
        for (int r = 2; r < n; r++) begin
            for (int k = 0; k <= g; k++) begin
                e.inst = g[1:0];
                e.addr = exp_addr[ADDR_W-1:0];
                e.data = model_row(rows[r-2], rows[r-1], rows[r], kw[k], int'(kt[k]), n);
                exp_q.push_back(e);
                exp_addr++;
            end
        end
        ip = ip + n + 1;
    endtask

    task automatic add_end();
        imem[ip] = DATA_W'(16'h00FF);
        ip++;
    endtask

    task automatic run_job(input int g, output int dones, output bit timeout);
        @(negedge clk);
        run_v[g] = 1'b1;
        @(negedge clk);
        run_v[g] = 1'b0;
        dones   = 0;
        timeout = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (done_v[g]) dones++;
            if (!busy_v[g]) begin
                timeout = 1'b0;
                break;
            end
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            n_cmp++;
            if ({busy_v[g], done_v[g], err_v[g], wr_v[g]} !== 4'b0000) begin
                n_bad++;
                $display("FAIL reset_flags[%0d]: got %b want 0000", g, {busy_v[g], done_v[g], err_v[g], wr_v[g]});
            end
            n_cmp++;
            if ({raddr_v[g], waddr_v[g], oaddr_v[g]} !== '0) begin
                n_bad++;
                $display("FAIL reset_addr[%0d]: got %h/%h/%h want 0", g, raddr_v[g], waddr_v[g], oaddr_v[g]);
            end
            n_cmp++;
            if (odata_v[g] !== '0) begin
                n_bad++;
                $display("FAIL reset_wdata[%0d]: got %h want 0", g, odata_v[g]);
            end
        end
    endtask

    task automatic test_basic();
        logic [DATA_W-1:0] rows[$];
        int dones, base, idx;
        bit to;
        wr_t e;
        new_job();
        set_kernel(0, 9'h1FF, 4'd4);
        for (int r = 0; r < 3; r++) rows.push_back('1);
        add_image(0, 3, rows);
        add_end();
        base = obs_cnt;
        run_job(0, dones, to);
        n_cmp++;
        if (to || dones != 1) begin
            n_bad++;
            $display("FAIL basic_done: got dones=%0d timeout=%0d want 1/0", dones, to);
        end
        n_cmp++;
        if (obs_cnt - base != exp_q.size()) begin
            n_bad++;
            $display("FAIL basic_count: got %0d want %0d", obs_cnt - base, exp_q.size());
        end
        idx = base;
        while (exp_q.size() > 0 && idx < obs_cnt) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs[idx] !== e) begin
                n_bad++;
                $display("FAIL basic_write: got %h want %h", obs[idx], e);
            end
            idx++;
        end
    endtask

    task automatic test_two_kernels();
        logic [DATA_W-1:0] rows[$];
        int dones, base, idx;
        bit to;
        wr_t e;
        new_job();
        set_kernel(0, 9'h1FF, 4'd4);
        set_kernel(1, 9'h000, 4'd4);
        for (int r = 0; r < 4; r++) rows.push_back('0);
        add_image(1, 4, rows);
        add_end();
        base = obs_cnt;
        run_job(1, dones, to);
        n_cmp++;
        if (to || dones != 1) begin
            n_bad++;
            $display("FAIL twok_done: got dones=%0d timeout=%0d want 1/0", dones, to);
        end
        n_cmp++;
        if (obs_cnt - base != exp_q.size()) begin
            n_bad++;
            $display("FAIL twok_count: got %0d want %0d", obs_cnt - base, exp_q.size());
        end
        idx = base;
        while (exp_q.size() > 0 && idx < obs_cnt) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs[idx] !== e) begin
                n_bad++;
                $display("FAIL twok_write: got %h want %h", obs[idx], e);
            end
            idx++;
        end
    endtask

    task automatic test_bad_header();
        int dones, base;
        bit to;
        new_job();
        imem[0] = DATA_W'(2);
        base = obs_cnt;
        run_job(0, dones, to);
        n_cmp++;
        if (err_v[0] !== 1'b1 || busy_v[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL bad_hdr_flags: got err=%b busy=%b want 1/0", err_v[0], busy_v[0]);
        end
        n_cmp++;
        if (to || dones != 0 || obs_cnt != base) begin
            n_bad++;
            $display("FAIL bad_hdr_quiet: got dones=%0d writes=%0d timeout=%0d want 0/0/0", dones, obs_cnt - base, to);
        end
        repeat (5) @(negedge clk);
        n_cmp++;
        if (err_v[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL bad_hdr_sticky: got %b want 1", err_v[0]);
        end
        new_job();
        add_end();
        run_job(0, dones, to);
        n_cmp++;
        if (err_v[0] !== 1'b0 || dones != 1 || to) begin
            n_bad++;
            $display("FAIL bad_hdr_clear: got err=%b dones=%0d want 0/1", err_v[0], dones);
        end
    endtask

    task automatic test_two_images();
        logic [DATA_W-1:0] rows[$];
        int dones, base, idx;
        bit to;
        wr_t e;
        new_job();
        set_kernel(0, 9'($urandom), 4'($urandom_range(0, 8)));
        for (int r = 0; r < 5; r++) rows.push_back(DATA_W'($urandom));
        add_image(0, 5, rows);
        rows.delete();
        for (int r = 0; r < 3; r++) rows.push_back('1);
        add_image(0, 3, rows);
        add_end();
        base = obs_cnt;
        run_job(0, dones, to);
        n_cmp++;
        if (to || dones != 1) begin
            n_bad++;
            $display("FAIL twoimg_done: got dones=%0d timeout=%0d want 1/0", dones, to);
        end
        n_cmp++;
        if (obs_cnt - base != exp_q.size()) begin
            n_bad++;
            $display("FAIL twoimg_count: got %0d want %0d", obs_cnt - base, exp_q.size());
        end
        idx = base;
        while (exp_q.size() > 0 && idx < obs_cnt) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs[idx] !== e) begin
                n_bad++;
                $display("FAIL twoimg_write: got %h want %h", obs[idx], e);
            end
            idx++;
        end
    endtask

    task automatic test_random();
        logic [DATA_W-1:0] rows[$];
        int dones, base, idx, n;
        bit to;
        wr_t e;
        for (int it = 0; it < 3; it++) begin
            new_job();
            for (int k = 0; k < 3; k++) begin
                if (it == 1 && k == 0) set_kernel(k, 9'($urandom), 4'($urandom_range(9, 15)));
                else                   set_kernel(k, 9'($urandom), 4'($urandom_range(0, 8)));
            end
            for (int img = 0; img < 2; img++) begin
                n = (img == 0 && it == 2) ? DATA_W : $urandom_range(3, DATA_W);
                rows.delete();
                for (int r = 0; r < n; r++) rows.push_back(DATA_W'($urandom));
                add_image(2, n, rows);
            end
            add_end();
            base = obs_cnt;
            run_job(2, dones, to);
            n_cmp++;
            if (to || dones != 1 || obs_cnt - base != exp_q.size()) begin
                n_bad++;
                $display("FAIL rand_job[%0d]: got dones=%0d writes=%0d want 1/%0d", it, dones, obs_cnt - base, exp_q.size());
            end
            idx = base;
            while (exp_q.size() > 0 && idx < obs_cnt) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (obs[idx] !== e) begin
                    n_bad++;
                    $display("FAIL rand_write[%0d]: got %h want %h", it, obs[idx], e);
                end
                idx++;
            end
        end
    endtask

    task automatic test_reset_mid_write();
        logic [DATA_W-1:0] rows[$];
        int base, seen, idx;
        wr_t e;
        new_job();
        for (int k = 0; k < 3; k++) set_kernel(k, 9'($urandom), 4'($urandom_range(0, 8)));
        for (int r = 0; r < 3; r++) rows.push_back(DATA_W'($urandom));
        add_image(2, 3, rows);
        add_end();
        base = obs_cnt;
        @(negedge clk);
        run_v[2] = 1'b1;
        @(negedge clk);
        run_v[2] = 1'b0;
        seen = 0;
        for (int c = 0; c < 500; c++) begin
            if (wr_v[2]) seen++;
            if (seen == 2) break;
            @(negedge clk);
        end
        n_cmp++;
        if (seen != 2) begin
            n_bad++;
            $display("FAIL rst_write_reach: got %0d writes want 2", seen);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({busy_v[2], done_v[2], err_v[2], wr_v[2]} !== 4'b0000) begin
            n_bad++;
            $display("FAIL rst_mid_flags: got %b want 0000", {busy_v[2], done_v[2], err_v[2], wr_v[2]});
        end
        n_cmp++;
        if ({raddr_v[2], waddr_v[2], oaddr_v[2], odata_v[2]} !== '0) begin
            n_bad++;
            $display("FAIL rst_mid_outputs: got %h/%h/%h/%h want 0", raddr_v[2], waddr_v[2], oaddr_v[2], odata_v[2]);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        n_cmp++;
        if (obs_cnt - base != 2) begin
            n_bad++;
            $display("FAIL rst_mid_count: got %0d want 2", obs_cnt - base);
        end
        idx = base;
        while (idx < base + 2 && idx < obs_cnt && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs[idx] !== e) begin
                n_bad++;
                $display("FAIL rst_mid_write: got %h want %h", obs[idx], e);
            end
            idx++;
        end
        exp_q.delete();
    endtask

    task automatic test_run_held();
        logic [DATA_W-1:0] rows[$];
        int dones, base, idx;
        wr_t e;
        new_job();
        set_kernel(0, 9'($urandom), 4'($urandom_range(0, 8)));
        set_kernel(1, 9'($urandom), 4'($urandom_range(0, 8)));
        for (int r = 0; r < 4; r++) rows.push_back(DATA_W'($urandom));
        add_image(1, 4, rows);
        add_end();
        base  = obs_cnt;
        dones = 0;
        @(negedge clk);
        run_v[1] = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (done_v[1]) begin
                dones++;
                run_v[1] = 1'b0;
                break;
            end
        end
        run_v[1] = 1'b0;
        repeat (5) @(negedge clk);
        n_cmp++;
        if (dones != 1 || busy_v[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL held_done: got dones=%0d busy=%b want 1/0", dones, busy_v[1]);
        end
        n_cmp++;
        if (obs_cnt - base != exp_q.size()) begin
            n_bad++;
            $display("FAIL held_count: got %0d want %0d", obs_cnt - base, exp_q.size());
        end
        idx = base;
        while (exp_q.size() > 0 && idx < obs_cnt) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs[idx] !== e) begin
                n_bad++;
                $display("FAIL held_write: got %h want %h", obs[idx], e);
            end
            idx++;
        end
    endtask

    task automatic test_end_only();
        int dones, base;
        bit to;
        new_job();
        add_end();
        base = obs_cnt;
        run_job(1, dones, to);
        n_cmp++;
        if (to || dones != 1 || obs_cnt != base || err_v[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL end_only: got dones=%0d writes=%0d err=%b want 1/0/0", dones, obs_cnt - base, err_v[1]);
        end
    endtask

    initial begin
        run_v = '0;
        reset = 1'b1;
        n_cmp = 0;
        n_bad = 0;
        for (int i = 0; i < 4096; i++) imem[i] = '0;
        for (int i = 0; i < 8; i++) begin
            wmem[i] = '0;
            kw[i]   = '0;
            kt[i]   = '0;
        end
        new_job();
        test_reset();
        test_basic();
        test_two_kernels();
        test_bad_header();
        test_two_images();
        test_random();
        test_end_only();
        test_run_held();
        test_reset_mid_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bnn_conv3x3_mk.md
BNN_CONV3X3_MK -- requirements
Module: bnn_conv3x3_mk

Interface
REQ-001 Parameter DATA_W, 16: row width in bits and maximum image side N; legal range 4..32.
REQ-002 Parameter ADDR_W, 12: width of every SRAM address port.
REQ-003 Parameter NUM_K, 2: kernels per image; legal range 1..8.
REQ-004 Port clk, input, 1: the single clock; all logic is on the rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port run, input, 1: start request, sampled in IDLE only.
REQ-007 Port busy, output, 1: high from the cycle after run is accepted until the return to IDLE.
REQ-008 Port done, output, 1: one-cycle pulse on a normal finish.
REQ-009 Port err, output, 1: sticky illegal-header flag, cleared on the next accepted run.
REQ-010 Ports dut_sram_read_address (output, ADDR_W) and sram_dut_read_data (input, DATA_W): input SRAM, 1-cycle read latency.
REQ-011 Ports dut_wmem_read_address (output, ADDR_W) and wmem_dut_read_data (input, 16): weight SRAM, 1-cycle read latency.
REQ-012 Ports dut_sram_write_address (output, ADDR_W), dut_sram_write_data (output, DATA_W) and wr_enable (output, 1): output SRAM write port.

Function
REQ-013 Weight word k at address k SHALL hold kernel bits [8:0], with bit 3r+c weighting window row r (0 = oldest) and column offset c, and threshold T in bits [12:9].
REQ-014 WLOAD SHALL read weight addresses 0..NUM_K-1 into NUM_K kernel registers in NUM_K+1 cycles.
REQ-015 Input layout SHALL be a header word N at the image base, followed by N row words; the next header follows immediately.
REQ-016 A header equal to END_MARK (16'h00FF, zero-extended) SHALL end the run: DONE, then IDLE.
REQ-017 A header with N<3 or N>DATA_W SHALL set err and go to IDLE without pulsing done.
REQ-018 States: IDLE -> WLOAD -> HDR -> ROWS <-> WRITE -> HDR, and HDR -> DONE -> IDLE.
REQ-019 ROWS SHALL shift each read row into a 3-row window (row0 = oldest); after each of rows 3..N, the block SHALL enter WRITE.
REQ-020 WRITE SHALL issue exactly NUM_K consecutive single-cycle writes, kernel 0 first, with input reads stalled.
REQ-021 Output bit i (0 <= i <= N-3) SHALL be 1 iff popcount over r,c of XNOR(row_r[i+c], w[3r+c]) > T; bits N-2..DATA_W-1 SHALL be 0.
REQ-022 Popcount SHALL be 4-bit unsigned; T values of 9..15 SHALL force all-zero output rows.
REQ-023 The write address SHALL be 0 on run acceptance and increment by 1 per write; it continues across images, giving image order, then row order, then kernel order.
REQ-024 The read address SHALL be 0 on run acceptance and increment by 1 per word consumed.
REQ-025 Address wrap-around at 2^ADDR_W SHALL be modulo with no error.
REQ-026 run asserted while busy SHALL be ignored.
REQ-027 wr_enable SHALL be high only in WRITE cycles.
REQ-028 Weights SHALL be loaded once per run and reused for every image.

Reset
REQ-029 When reset is high at a clock edge, the next state SHALL be IDLE, irrespective of run.
REQ-030 At that edge, busy, done, err, wr_enable, all addresses and the window SHALL be set to 0.
REQ-031 Reset mid-WRITE SHALL suppress every remaining write of that row; no partial-state carryover is allowed.

Structure
REQ-032 Package bnn_pkg SHALL hold the state enum, END_MARK, the weight field positions and the legal N bounds.
REQ-033 A combinational sub-module bnn_window_eval SHALL compute one DATA_W-bit output row from the window, a kernel and T.
REQ-034 The top SHALL select among the NUM_K kernels with a kernel counter.

Verification
REQ-035 Test: NUM_K=1, w=9'h1FF, T=4, N=3, rows all 1s, then 00FF -> one write, addr 0, data 16'h0001, then a done pulse.
REQ-036 Test: NUM_K=2, kernel0 all 1s / T=4, kernel1 all 0s / T=4, N=4, rows all 0s -> writes at 0..3 with data 0000, 0003, 0000, 0003.
REQ-037 Test: header N=2 -> err=1, no writes, done stays 0, busy drops; the next run clears err.
REQ-038 Test: two images with N=5 and N=3, NUM_K=1 -> writes at addresses 0,1,2 then 3, with bits above N-3 zero.
REQ-039 Test: reset pulsed during the second write cycle of WRITE (NUM_K=3) -> no further writes, and all outputs are 0 at the next edge.
REQ-040 Test: run held high throughout the job -> exactly one job executed per run acceptance from IDLE.
